conv_serie_paralelo_4b: RTL
===========================

// Module: conv_serie_paralelo_4b
// PURPOSE
//  Serial-to-parallel converter; the stage directly upstream of the 4-bit
//  parallel-parallel register.
//  Assembles WIDTH serial bits into a word, then presents it on 'word' with a
//  one-cycle 'valid' strobe. The downstream register samples 'word' on its D input.
//  Framing comes from a 'start' pulse. Bit sampling is paced by a 'bit_en' tick,
//  so slow serial sources share the system clock.
// PARAMETERS
//  WIDTH      4  bits per frame (>=2); word width
//  MSB_FIRST  1  1: first serial bit lands in word[WIDTH-1]; 0: in word[0]
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      asynchronous reset, active-high
//  din     in   1      serial data, sampled only when in SHIFT and bit_en=1
//  bit_en  in   1      bit-sample tick (tie 1 for one bit per clock)
//  start   in   1      begin frame; honoured only in IDLE
//  word    out  WIDTH  last completed frame, held until next completion
//  valid   out  1      1-cycle strobe: word updated this cycle
//  busy    out  1      1 while a frame is being assembled (state SHIFT)
// BEHAVIOUR
//  Reset (rst=1, async): state=IDLE, bit counter=0, shift reg=0, word=0,
//   valid=0, busy=0. Reset mid-frame discards the partial frame; word is cleared.
//  FSM, 2 states:
//   IDLE : busy=0. On an edge with start=1: go to SHIFT, counter=0.
//          din is NOT sampled in the start cycle. bit_en is ignored.
//   SHIFT: busy=1. On each edge with bit_en=1: shift din in, counter++.
//          Edges with bit_en=0: hold everything.
//          On the edge capturing bit WIDTH: word <= assembled value
//          (including this bit), valid=1, counter=0, state -> IDLE.
//  valid: registered; high exactly one cycle after each completion edge;
//   otherwise 0. Never asserted in the start cycle or during reset.
//  Bit order: MSB_FIRST=1 shifts left, din enters bit 0;
//   MSB_FIRST=0 shifts right, din enters bit WIDTH-1.
//  Latency with bit_en tied 1: start seen at edge E0; bits sampled at
//   E1..E_WIDTH; word/valid update at E_WIDTH.
//  Counter width: $clog2(WIDTH+1); never exceeds WIDTH.
//  Simultaneous events:
//   - start while busy, including the final-bit edge: ignored. No restart and
//     no frame truncation.
//   - Back-to-back frames: start asserted in the valid cycle (state IDLE) is
//     accepted, giving gapless framing with one idle cycle.
//  word is stable between completions. busy falls in the same cycle valid rises.
// TESTING
//  1 Reset: assert rst asynchronously, no clk edge -> word=0, valid=0, busy=0
//    immediately.
//  2 MSB_FIRST=1, bit_en=1: start at E0, din=1,0,1,1 at E1..E4 -> at E4
//    word=4'b1011, valid=1 for 1 cycle, busy 1->0.
//  3 MSB_FIRST=0, same stream -> word=4'b1101, valid single cycle.
//  4 bit_en=1 only every 3rd clock, frame 0,1,1,0 (MSB first) -> word=4'b0110;
//    valid exactly once; busy high throughout the 12-clock frame.
//  5 start pulsed at bit 2 of frame 1,1,0,0 -> ignored, word=4'b1100.
//    Then start in the valid cycle with frame 1,0,0,1 -> word=4'b1001, no lost bits.
//  6 Complete word 4'b1010, then start new frame, rst after 2 bits -> word=0,
//    busy=0, no valid. Next full frame 0,1,1,1 -> word=4'b0111.

Source files
------------

// File: rtl/conv_serie_paralelo_4b.sv
// Purpose : serial-to-parallel converter; assembles WIDTH serial bits (paced by bit_en) into a word.
// Latency : start seen at E0, bits sampled on bit_en edges; word/valid update on the edge taking bit WIDTH.
// Backpr. : none; start is ignored while a frame is in progress, bit_en=0 stalls the frame in place.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous reset, active-high; clears state, word, valid and busy
//   din     serial data, sampled only in SHIFT on edges with bit_en=1
//   bit_en  bit-sample tick (tie high for one bit per clock)
//   start   begin a frame; honoured only while idle
//   word    last completed frame, held until the next completion
//   valid   one-cycle strobe, high in the cycle after a completion edge
//   busy    high while a frame is being assembled
module conv_serie_paralelo_4b #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             bit_en,
    input  logic             start,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shifted;

    // Shift register with the incoming bit already applied; used both for the
    // running value and for the completed word on the final-bit edge, so the
    // last bit lands in the word in the same cycle it is sampled.
    always_comb begin
        shifted = sr_q;
        if (MSB_FIRST) begin
            shifted = {sr_q[WIDTH-2:0], din};
        end else begin
            shifted = {din, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        word_d  = word_q;
        valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // din is deliberately not sampled in the start cycle.
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            ST_SHIFT: begin
                // start is ignored here, including on the final-bit edge.
                if (bit_en) begin
                    sr_d = shifted;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        word_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // busy is registered from the next state so it drops in the same
        // cycle valid rises.
        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign word  = word_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule
